// File: rtl/run_control.sv
// run_control: CPU run/step/burst clock-enable controller.
// Debounces a raw step button, divides the clock into free-run ticks and issues
// one-cycle cpu_clock_enable pulses according to the selected mode.
// Optional feature macro: RUN_CONTROL_BREAKPOINT_EN enables PC breakpoints
// (BREAK state); without it the breakpoint inputs are ignored.
module run_control #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIVIDE      = 2,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic                   step_button,
    input  logic [COUNT_WIDTH-1:0] burst_count,
    input  logic [31:0]            cpu_pc,
    input  logic [31:0]            breakpoint_addr,
    input  logic                   breakpoint_valid,
    output logic                   cpu_clock_enable,
    output logic                   halted,
    output logic                   breakpoint_hit,
    output logic [COUNT_WIDTH-1:0] steps_done
);

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_BURST,
        S_BREAK
    } state_e;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (RUN_DIVIDE > 1) ? $clog2(RUN_DIVIDE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIVIDE - 1);

    mode_e                  mode_sel;
    state_e                 state, state_next;
    logic [1:0]             sync_ff;
    logic                   db_level;
    logic                   db_prev;
    logic [DB_W-1:0]        db_count;
    logic                   step_req;
    logic [PS_W-1:0]        prescale;
    logic                   tick;
    logic                   bp_match;
    logic                   enable_next;
    logic [COUNT_WIDTH-1:0] remaining, remaining_next;

    assign mode_sel = mode_e'(mode);

    // Synchronize the raw button, then accept a new level only after
    // DEBOUNCE_CYCLES consecutive samples that differ from the current one.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff  <= 2'b00;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_count <= '0;
        end else begin
            sync_ff <= {sync_ff[0], step_button};
            db_prev <= db_level;
            if (sync_ff[1] == db_level) begin
                db_count <= '0;
            end else if (db_count == DB_LAST) begin
                db_level <= sync_ff[1];
                db_count <= '0;
            end else begin
                db_count <= db_count + DB_W'(1);
            end
        end
    end

    // One request per rising edge of the debounced level, however long it is held.
    assign step_req = db_level & ~db_prev;

    // Free-running prescaler; mode never touches it so tick phase is stable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (prescale == PS_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PS_W'(1);
        end
    end

    assign tick = (prescale == PS_LAST);

`ifdef RUN_CONTROL_BREAKPOINT_EN
    assign bp_match       = breakpoint_valid && (cpu_pc == breakpoint_addr);
    assign breakpoint_hit = (state == S_BREAK);
`else
    logic unused_bp;
    assign unused_bp      = ^{cpu_pc, breakpoint_addr, breakpoint_valid};
    assign bp_match       = 1'b0;
    assign breakpoint_hit = 1'b0;
`endif

    assign halted = (state == S_IDLE) || (state == S_BREAK);

    // Next-state, next-enable and burst countdown decode.
    // NOTE: every output of this block is given a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        enable_next    = 1'b0;
        remaining_next = remaining;
        unique case (state)
            S_IDLE: begin
                if (mode_sel == MODE_RUN) begin
                    state_next = S_RUN;
                end else if (step_req && mode_sel == MODE_STEP) begin
                    state_next = S_STEP;
                end else if (step_req && mode_sel == MODE_BURST && burst_count != '0) begin
                    state_next     = S_BURST;
                    remaining_next = burst_count;
                end
            end
            S_RUN: begin
                if (mode_sel != MODE_RUN) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (bp_match) begin
                        state_next = S_BREAK;
                    end else begin
                        enable_next = 1'b1;
                    end
                end
            end
            S_STEP: begin
                // Breakpoint deliberately not checked: this is how BREAK steps past it.
                if (tick) begin
                    enable_next = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_BURST: begin
                if (mode_sel != MODE_BURST) begin
                    state_next = S_IDLE;
                end else if (tick) begin
                    if (bp_match) begin
                        state_next = S_BREAK;
                    end else begin
                        enable_next    = 1'b1;
                        remaining_next = remaining - COUNT_WIDTH'(1);
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state_next = S_IDLE;
                        end
                    end
                end
            end
            S_BREAK: begin
                if (step_req) begin
                    state_next = S_STEP;
                end else if (mode_sel == MODE_HALT) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, registered enable pulse, burst countdown and enable tally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cpu_clock_enable <= 1'b0;
            remaining        <= '0;
            steps_done       <= '0;
        end else begin
            state            <= state_next;
            cpu_clock_enable <= enable_next;
            remaining        <= remaining_next;
            if (enable_next) begin
                steps_done <= steps_done + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Directed testbench for run_control (DEBOUNCE_CYCLES=4, RUN_DIVIDE=2, COUNT_WIDTH=8).
// Breakpoint scenario follows RUN_CONTROL_BREAKPOINT_EN when defined.
module tb_run_control;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int RUN_DIVIDE      = 2;
    localparam int COUNT_WIDTH     = 8;

    logic                   clock;
    logic                   reset;
    logic [1:0]             mode;
    logic                   step_button;
    logic [COUNT_WIDTH-1:0] burst_count;
    logic [31:0]            cpu_pc;
    logic [31:0]            breakpoint_addr;
    logic                   breakpoint_valid;
    logic                   cpu_clock_enable;
    logic                   halted;
    logic                   breakpoint_hit;
    logic [COUNT_WIDTH-1:0] steps_done;

    int   vectors;
    int   miscompares;
    int   en_count;
    int   cyc;
    int   first_en;
    int   last_en;
    logic prev_en;

    run_control #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RUN_DIVIDE     (RUN_DIVIDE),
        .COUNT_WIDTH    (COUNT_WIDTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mode            (mode),
        .step_button     (step_button),
        .burst_count     (burst_count),
        .cpu_pc          (cpu_pc),
        .breakpoint_addr (breakpoint_addr),
        .breakpoint_valid(breakpoint_valid),
        .cpu_clock_enable(cpu_clock_enable),
        .halted          (halted),
        .breakpoint_hit  (breakpoint_hit),
        .steps_done      (steps_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n cycles, sampling 1 time unit after each edge. Tallies enables,
    // models the CPU PC advancing by 4 per enable and flags back-to-back pulses.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cpu_clock_enable) begin
                vectors++;
                if (prev_en) begin
                    miscompares++;
                    $display("FAIL back_to_back_enable: enable high twice in a row at cycle %0d, required gap", cyc);
                end
                if (en_count == 0) first_en = cyc;
                last_en = cyc;
                en_count++;
                cpu_pc = cpu_pc + 32'd4;
            end
            prev_en = cpu_clock_enable;
        end
    endtask

    task automatic press(input int len);
        step_button = 1'b1;
        run_cycles(len);
        step_button = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        mode        = 2'b00;
        step_button = 1'b0;
        burst_count = '0;
        cpu_pc      = '0;
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        en_count = 0;
        cyc      = 0;
        first_en = 0;
        last_en  = 0;
        prev_en  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        vectors++;
        if (cpu_clock_enable !== 1'b0 || halted !== 1'b1 || breakpoint_hit !== 1'b0 || steps_done !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: en=%b halted=%b bp_hit=%b steps=%0d, required 0 1 0 0",
                     cpu_clock_enable, halted, breakpoint_hit, steps_done);
        end
        do_reset();
    endtask

    task automatic test_run();
        do_reset();
        mode = 2'b01;
        run_cycles(20);
        vectors++;
        if (en_count != 10 || steps_done !== 8'd10) begin
            miscompares++;
            $display("FAIL run_count: enables=%0d steps=%0d, required 10 10", en_count, steps_done);
        end
        vectors++;
        if (first_en != 2 || last_en != 20) begin
            miscompares++;
            $display("FAIL run_phase: first=%0d last=%0d, required 2 20", first_en, last_en);
        end
        mode = 2'b00;
        run_cycles(1);
        vectors++;
        if (halted !== 1'b1 || cpu_clock_enable !== 1'b0) begin
            miscompares++;
            $display("FAIL run_stop: halted=%b en=%b, required 1 0", halted, cpu_clock_enable);
        end
        run_cycles(6);
        vectors++;
        if (en_count != 10) begin
            miscompares++;
            $display("FAIL run_after_stop: enables=%0d, required 10", en_count);
        end
    endtask

    task automatic test_single_step();
        do_reset();
        mode = 2'b10;
        press(3);
        run_cycles(15);
        vectors++;
        if (en_count != 0 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL step_bounce: enables=%0d halted=%b, required 0 1", en_count, halted);
        end
        press(10);
        run_cycles(10);
        vectors++;
        if (en_count != 1 || steps_done !== 8'd1 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL step_once: enables=%0d steps=%0d halted=%b, required 1 1 1", en_count, steps_done, halted);
        end
    endtask

    task automatic test_burst();
        int guard;
        do_reset();
        mode        = 2'b11;
        burst_count = 8'd5;
        press(10);
        run_cycles(30);
        vectors++;
        if (en_count != 5 || steps_done !== 8'd5 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_five: enables=%0d steps=%0d halted=%b, required 5 5 1", en_count, steps_done, halted);
        end
        vectors++;
        if (last_en - first_en != 8) begin
            miscompares++;
            $display("FAIL burst_spacing: span=%0d cycles, required 8", last_en - first_en);
        end
        burst_count = 8'd0;
        press(10);
        run_cycles(20);
        vectors++;
        if (en_count != 5 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_zero: enables=%0d halted=%b, required 5 1", en_count, halted);
        end
        burst_count = 8'd20;
        press(10);
        guard = 0;
        while (en_count < 7 && guard < 40) begin
            run_cycles(1);
            guard++;
        end
        vectors++;
        if (en_count != 7) begin
            miscompares++;
            $display("FAIL burst_abort_start: enables=%0d, required 7", en_count);
        end
        mode = 2'b00;
        run_cycles(10);
        vectors++;
        if (en_count != 7 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_abort: enables=%0d halted=%b, required 7 1", en_count, halted);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        breakpoint_addr  = 32'h10;
        breakpoint_valid = 1'b1;
        mode             = 2'b01;
        run_cycles(30);
`ifdef RUN_CONTROL_BREAKPOINT_EN
        vectors++;
        if (en_count != 4 || breakpoint_hit !== 1'b1 || halted !== 1'b1 || steps_done !== 8'd4) begin
            miscompares++;
            $display("FAIL bp_stop: enables=%0d bp_hit=%b halted=%b steps=%0d, required 4 1 1 4",
                     en_count, breakpoint_hit, halted, steps_done);
        end
        mode = 2'b10;
        press(10);
        run_cycles(10);
        vectors++;
        if (en_count != 5 || breakpoint_hit !== 1'b0 || halted !== 1'b1 || steps_done !== 8'd5) begin
            miscompares++;
            $display("FAIL bp_step_past: enables=%0d bp_hit=%b halted=%b steps=%0d, required 5 0 1 5",
                     en_count, breakpoint_hit, halted, steps_done);
        end
`else
        vectors++;
        if (en_count != 15 || breakpoint_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ignored: enables=%0d bp_hit=%b, required 15 0", en_count, breakpoint_hit);
        end
`endif
        breakpoint_valid = 1'b0;
        mode             = 2'b00;
        run_cycles(2);
    endtask

    task automatic test_wrap_and_reset();
        int guard;
        do_reset();
        mode  = 2'b01;
        guard = 0;
        while (en_count < 255 && guard < 600) begin
            run_cycles(1);
            guard++;
        end
        mode = 2'b00;
        run_cycles(4);
        vectors++;
        if (en_count != 255 || steps_done !== 8'd255) begin
            miscompares++;
            $display("FAIL wrap_pre: enables=%0d steps=%0d, required 255 255", en_count, steps_done);
        end
        mode = 2'b10;
        press(10);
        run_cycles(10);
        vectors++;
        if (en_count != 256 || steps_done !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap: enables=%0d steps=%0d, required 256 0", en_count, steps_done);
        end

        do_reset();
        mode        = 2'b11;
        burst_count = 8'd100;
        press(10);
        guard = 0;
        while (en_count < 2 && guard < 40) begin
            run_cycles(1);
            guard++;
        end
        vectors++;
        if (cpu_clock_enable !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_burst_pre: en=%b, required 1", cpu_clock_enable);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (cpu_clock_enable !== 1'b0 || steps_done !== 8'd0 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_burst_async: en=%b steps=%0d halted=%b, required 0 0 1",
                     cpu_clock_enable, steps_done, halted);
        end
        #2;
        reset    = 1'b0;
        en_count = 0;
        prev_en  = 1'b0;
        run_cycles(20);
        vectors++;
        if (en_count != 0 || halted !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_burst_after: enables=%0d halted=%b, required 0 1", en_count, halted);
        end
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        en_count         = 0;
        cyc              = 0;
        first_en         = 0;
        last_en          = 0;
        prev_en          = 1'b0;
        reset            = 1'b1;
        mode             = 2'b00;
        step_button      = 1'b0;
        burst_count      = '0;
        cpu_pc           = '0;
        breakpoint_addr  = '0;
        breakpoint_valid = 1'b0;

        test_reset();
        test_run();
        test_single_step();
        test_burst();
        test_breakpoint();
        test_wrap_and_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
